store_buffer: RTL

Circular store buffer between dispatch/execute and the data-memory port. It allocates one entry per dispatched store and records address/data when the store executes. It exports the per-entry written-back vector and the oldest-entry pointer that the issue stage's previous-store check consumes. Stores retired by the ROB drain to memory in program order through a valid/ready port.

---
 rtl/store_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: circular store buffer between dispatch/execute and the
// data-memory write port.
//   alloc_*   : dispatch allocates one entry per store (index = tail)
//   wb_*      : execute records address/data and sets the entry's wb bit
//   rob_commit_v_i : ROB retires the oldest uncommitted store
//   flush_i   : squash every uncommitted entry
//   sb_*      : written-back vector, head pointer and empty flag for issue
//   mem_*     : in-order drain of committed stores via valid/ready
module store_buffer #(
    parameter  int unsigned SB_ENTRY   = 8,
    parameter  int unsigned ADDR_WIDTH = 16,
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned PW         = $clog2(SB_ENTRY)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  alloc_v_i,
    output logic                  alloc_ready_o,
    output logic [PW-1:0]         alloc_sb_num_o,
    input  logic                  wb_v_i,
    input  logic [PW-1:0]         wb_sb_num_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  rob_commit_v_i,
    input  logic                  flush_i,
    output logic [SB_ENTRY-1:0]   sb_wb_vector_o,
    output logic [PW-1:0]         sb_commit_pt_o,
    output logic                  sb_empty_o,
    output logic                  mem_v_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_ready_i
);

    localparam int unsigned PTRW = PW + 1;

    logic [PTRW-1:0]       head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [SB_ENTRY-1:0]   wb_q, wb_d;
    logic [ADDR_WIDTH-1:0] addr_q [SB_ENTRY];
    logic [ADDR_WIDTH-1:0] addr_d [SB_ENTRY];
    logic [DATA_WIDTH-1:0] data_q [SB_ENTRY];
    logic [DATA_WIDTH-1:0] data_d [SB_ENTRY];

    logic [PW-1:0] head_idx, cmt_idx, tail_idx;
    logic          full, wb_live, commit_ok;
    logic          alloc_fire, wb_fire, commit_fire, drain_fire;

    assign head_idx = head_q[PW-1:0];
    assign cmt_idx  = cmt_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    assign full = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);

    // An entry is live when its distance from head is below the occupancy.
    assign wb_live   = {1'b0, PW'(wb_sb_num_i - head_idx)} < PTRW'(tail_q - head_q);
    assign commit_ok = (cmt_q != tail_q) && wb_q[cmt_idx];

    assign alloc_fire  = alloc_v_i && !full && !flush_i;
    assign wb_fire     = wb_v_i && !flush_i && wb_live;
    assign commit_fire = rob_commit_v_i && commit_ok;
    assign drain_fire  = mem_v_o && mem_ready_i;

    // Outputs are pure functions of state (no bypass paths).
    assign alloc_ready_o  = !full;
    assign alloc_sb_num_o = tail_idx;
    assign sb_wb_vector_o = wb_q;
    assign sb_commit_pt_o = head_idx;
    assign sb_empty_o     = (head_q == tail_q);
    assign mem_v_o        = (head_q != cmt_q) && wb_q[head_idx];
    assign mem_addr_o     = addr_q[head_idx];
    assign mem_data_o     = data_q[head_idx];

    // Next-state: pointers, wb bits and entry payloads.
    always_comb begin
        logic [PW-1:0] sq_off;
        sq_off = '0;
        head_d = head_q + PTRW'(drain_fire);
        cmt_d  = cmt_q + PTRW'(commit_fire);
        tail_d = flush_i ? cmt_d : tail_q + PTRW'(alloc_fire);
        wb_d   = wb_q;
        addr_d = addr_q;
        data_d = data_q;

        if (wb_fire) begin
            wb_d[wb_sb_num_i]   = 1'b1;
            addr_d[wb_sb_num_i] = wb_addr_i;
            data_d[wb_sb_num_i] = wb_data_i;
        end
        if (drain_fire) begin
            wb_d[head_idx] = 1'b0;
        end
        // Squashed entries are those from the post-commit cmt up to the old tail.
        if (flush_i) begin
            for (int unsigned i = 0; i < SB_ENTRY; i++) begin
                sq_off = PW'(i) - cmt_d[PW-1:0];
                if ({1'b0, sq_off} < PTRW'(tail_q - cmt_d)) begin
                    wb_d[i] = 1'b0;
                end
            end
        end
    end

    // Control state with async reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            wb_q   <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            wb_q   <= wb_d;
        end
    end

    // Payload storage; contents of non-written-back entries are don't-care.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Illegal-usage checks.
    a_wb_live: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (wb_v_i && !flush_i) |-> wb_live)
        else $error("store_buffer: writeback to non-live entry");

    a_commit_ok: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        rob_commit_v_i |-> commit_ok)
        else $error("store_buffer: illegal commit");

    a_wb_drain: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(wb_fire && drain_fire && (wb_sb_num_i == head_idx)))
        else $error("store_buffer: writeback and drain on same entry");

endmodule
